// File: rtl/alu_resp_unit.sv
// ALU with a 2-entry response FIFO and a saturating overflow counter.
// Results are computed on the accept edge and presented from the FIFO head.
module alu_resp_unit #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [2:0]       req_op,
    input  logic             req_unsig,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_compout,
    output logic             rsp_illegal,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_FW = 2;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              overflow;
        logic              compout;
        logic              illegal;
    } rsp_entry_t;

    rsp_entry_t        mem_q [0:DEPTH-1];
    logic [CNT_FW-1:0] count_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [CNT_W-1:0]  ovf_count_q;

    rsp_entry_t        new_entry;
    rsp_entry_t        head;
    logic [DATA_W:0]   add_full;
    logic [DATA_W:0]   sub_full;
    logic              accept;
    logic              dequeue;

    // Operation datapath; bit DATA_W of sub_full is the unsigned borrow
    always_comb begin
        add_full  = {1'b0, req_a} + {1'b0, req_b};
        sub_full  = {1'b0, req_a} - {1'b0, req_b};
        new_entry = '0;
        new_entry.compout = req_unsig ? (req_a < req_b)
                                      : ($signed(req_a) < $signed(req_b));
        case (req_op)
            OP_AND: new_entry.result = req_a & req_b;
            OP_OR:  new_entry.result = req_a | req_b;
            OP_NOR: new_entry.result = ~(req_a | req_b);
            OP_XOR: new_entry.result = req_a ^ req_b;
            OP_ADD: begin
                new_entry.result   = add_full[DATA_W-1:0];
                new_entry.overflow = req_unsig ? add_full[DATA_W]
                    : ((req_a[DATA_W-1] == req_b[DATA_W-1]) &&
                       (add_full[DATA_W-1] != req_a[DATA_W-1]));
            end
            OP_SUB: begin
                new_entry.result   = sub_full[DATA_W-1:0];
                new_entry.overflow = req_unsig ? sub_full[DATA_W]
                    : ((req_a[DATA_W-1] != req_b[DATA_W-1]) &&
                       (sub_full[DATA_W-1] != req_a[DATA_W-1]));
            end
            default: new_entry.illegal = 1'b1;
        endcase
    end

    assign req_ready = !rst && (count_q != CNT_FW'(DEPTH));
    assign rsp_valid = (count_q != '0);
    assign accept    = req_valid && req_ready;
    assign dequeue   = rsp_valid && rsp_ready;

    assign head         = mem_q[rd_ptr_q];
    assign rsp_result   = head.result;
    assign rsp_overflow = head.overflow;
    assign rsp_compout  = head.compout;
    assign rsp_illegal  = head.illegal;
    assign ovf_count    = ovf_count_q;

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= new_entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (dequeue) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({accept, dequeue})
                2'b10:   count_q <= count_q + CNT_FW'(1);
                2'b01:   count_q <= count_q - CNT_FW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Overflow statistics: clear wins over increment, saturates at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count_q <= '0;
        end else if (stat_clr) begin
            ovf_count_q <= '0;
        end else if (accept && new_entry.overflow && (ovf_count_q != '1)) begin
            ovf_count_q <= ovf_count_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_resp_unit.sv
// Bench for alu_resp_unit: directed literal cases plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_alu_resp_unit;

    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam longint      SMAX    = 64'sd2147483647;
    localparam longint      SMIN    = -64'sd2147483648;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [2:0]       req_op;
    logic             req_unsig;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_overflow;
    logic             rsp_compout;
    logic             rsp_illegal;
    logic             stat_clr;
    logic [CNT_W-1:0] ovf_count;

    alu_resp_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_unsig(req_unsig),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
        .rsp_compout(rsp_compout), .rsp_illegal(rsp_illegal),
        .stat_clr(stat_clr), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic        o;
        logic        c;
        logic        i;
    } exp_t;

    exp_t q[$];
    int   m_cnt;
    int   n_pass;
    int   n_total;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        else
            n_pass++;
    endtask

    // Reference semantics using wide integer arithmetic
    function automatic exp_t model_op(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic u);
        exp_t   e;
        longint sa, sb, ua, ub, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        e.r = '0; e.o = 1'b0; e.i = 1'b0;
        e.c = u ? (ua < ub) : (sa < sb);
        case (op)
            3'd0: e.r = a & b;
            3'd1: e.r = a | b;
            3'd4: e.r = ~(a | b);
            3'd5: e.r = a ^ b;
            3'd2: begin
                e.r = 32'(ua + ub);
                s   = sa + sb;
                e.o = u ? ((ua + ub) > 64'sh0FFFFFFFF) : (s > SMAX || s < SMIN);
            end
            3'd6: begin
                e.r = 32'(ua - ub);
                s   = sa - sb;
                e.o = u ? (ua < ub) : (s > SMAX || s < SMIN);
            end
            default: e.i = 1'b1;
        endcase
        return e;
    endfunction

    task automatic compare();
        check("req_ready", 64'(req_ready), 64'(!rst && q.size() < 2));
        check("rsp_valid", 64'(rsp_valid), 64'(q.size() != 0));
        check("ovf_count", 64'(ovf_count), 64'(m_cnt));
        if (q.size() != 0) begin
            check("rsp_result",   64'(rsp_result),   64'(q[0].r));
            check("rsp_overflow", 64'(rsp_overflow), 64'(q[0].o));
            check("rsp_compout",  64'(rsp_compout),  64'(q[0].c));
            check("rsp_illegal",  64'(rsp_illegal),  64'(q[0].i));
        end
    endtask

    // Advance model and DUT by one edge using the currently driven inputs
    task automatic cycle();
        exp_t e;
        bit   acc, deq;
        if (rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            acc = req_valid && (q.size() < 2);
            deq = rsp_ready && (q.size() != 0);
            e   = model_op(req_op, req_a, req_b, req_unsig);
            if (deq) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (stat_clr) m_cnt = 0;
            else if (acc && e.o && m_cnt < CNT_MAX) m_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic set_req(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic u);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_unsig = u;
    endtask

    // Single request with literal expectations on the head entry, then drain
    task automatic send_lit(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic u, input logic [31:0] er,
                            input logic eo, input logic ec, input logic ei);
        set_req(op, a, b, u);
        rsp_ready = 1'b1;
        cycle();
        req_valid = 1'b0;
        check({name, "_valid"}, 64'(rsp_valid), 64'd1);
        check({name, "_result"}, 64'(rsp_result), 64'(er));
        check({name, "_ovf"}, 64'(rsp_overflow), 64'(eo));
        check({name, "_cmp"}, 64'(rsp_compout), 64'(ec));
        check({name, "_ill"}, 64'(rsp_illegal), 64'(ei));
        cycle();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] edges [5] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h1};
        if ($urandom_range(0, 2) == 0) return edges[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        n_pass = 0; n_total = 0; m_cnt = 0;
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
        req_unsig = 1'b0; rsp_ready = 1'b0; stat_clr = 1'b0;
        cycle();
        cycle();
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_result", 64'(rsp_result), 64'd0);
        check("rst_flags", 64'({rsp_overflow, rsp_compout, rsp_illegal}), 64'd0);
        check("rst_cnt", 64'(ovf_count), 64'd0);
        check("rst_ready_low", 64'(req_ready), 64'd0);
        rst = 1'b0;
        #1 check("rst_ready_high", 64'(req_ready), 64'd1);

        send_lit("add_s_ovf", 3'b010, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0);
        check("cnt_after_add", 64'(ovf_count), 64'd1);
        send_lit("add_u_ovf", 3'b010, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        send_lit("sub_u_ovf", 3'b110, 32'h1, 32'h2, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
        send_lit("sub_s_ovf", 3'b110, 32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        send_lit("and_cmp_s", 3'b000, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h1, 1'b0, 1'b1, 1'b0);
        send_lit("and_cmp_u", 3'b000, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
        send_lit("nor", 3'b100, 32'hF0F00000, 32'h0000000F, 1'b1, 32'h0F0FFFF0, 1'b0, 1'b0, 1'b0);
        send_lit("ill_011", 3'b011, 32'h5, 32'h3, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        send_lit("ill_111", 3'b111, 32'h1, 32'h2, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
        check("cnt_after_dir", 64'(ovf_count), 64'd4);

        // Backpressure: two accepted, third stalls until drain begins
        rsp_ready = 1'b0;
        set_req(3'b000, 32'hF0F01234, 32'h0FF0FF00, 1'b1);
        cycle();
        req_op = 3'b001;
        cycle();
        req_op = 3'b101;
        check("bp_full_ready", 64'(req_ready), 64'd0);
        cycle();
        check("bp_head_and", 64'(rsp_result), 64'h00F01200);
        rsp_ready = 1'b1;
        cycle();
        check("bp_head_or", 64'(rsp_result), 64'hFFF0FF34);
        check("bp_ready_again", 64'(req_ready), 64'd1);
        cycle();
        req_valid = 1'b0;
        check("bp_head_xor", 64'(rsp_result), 64'hFF00ED34);
        cycle();
        check("bp_drained", 64'(rsp_valid), 64'd0);

        // Saturation and clear priority
        stat_clr = 1'b1;
        cycle();
        stat_clr = 1'b0;
        set_req(3'b010, 32'hFFFFFFFF, 32'h1, 1'b1);
        for (int i = 0; i < 260; i++) cycle();
        check("sat_cnt", 64'(ovf_count), 64'd255);
        stat_clr = 1'b1;
        cycle();
        check("clr_priority", 64'(ovf_count), 64'd0);
        stat_clr = 1'b0;
        req_valid = 1'b0;
        cycle();

        // Reset with two entries queued and a same-edge request/dequeue
        rsp_ready = 1'b0;
        set_req(3'b010, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
        cycle();
        cycle();
        check("pre_rst_full", 64'(req_ready), 64'd0);
        rst = 1'b1;
        rsp_ready = 1'b1;
        cycle();
        check("midrst_valid", 64'(rsp_valid), 64'd0);
        check("midrst_cnt", 64'(ovf_count), 64'd0);
        check("midrst_result", 64'(rsp_result), 64'd0);
        rst = 1'b0;
        req_valid = 1'b0;
        #1 check("midrst_ready", 64'(req_ready), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            stat_clr  = ($urandom_range(0, 31) == 0);
            rsp_ready = ($urandom_range(0, 9) < 6);
            req_valid = ($urandom_range(0, 3) != 0);
            req_op    = 3'($urandom_range(0, 7));
            req_a     = rand_word();
            req_b     = rand_word();
            req_unsig = 1'($urandom_range(0, 1));
            cycle();
        end
        rst = 1'b0; stat_clr = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        cycle();
        cycle();
        check("final_empty", 64'(rsp_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
